// File: rtl/fetch_decode_unit_pkg.sv
// Shared widths, LEGv8 opcode constants and control-word types for the fetch/decode front end.
package fetch_decode_unit_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
  localparam logic [5:0]  OP_B    = 6'b00_0101;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    uncond_branch;
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    reg2_loc;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

endpackage

// File: rtl/fetch_decode_unit_reg_file.sv
// 32 x WORD register file: two asynchronous read ports, one write port on the rising edge.
// X31 reads as zero and ignores writes; reset clears every register.
module reg_file_32x64
  import fetch_decode_unit_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] regs_r [32];

  // Register storage: clear on reset, otherwise accept the write-back value
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (waddr != 5'd31)) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents; there is no write-to-read bypass
  assign rdata1 = (raddr1 == 5'd31) ? '0 : regs_r[raddr1];
  assign rdata2 = (raddr2 == 5'd31) ? '0 : regs_r[raddr2];

endmodule

// File: rtl/fetch_decode_unit.sv
// LEGv8 single-cycle front end: PC register, instruction ROM, control decode,
// immediate sign extension and the register file.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int WORD       = fetch_decode_unit_pkg::WORD,
  parameter int INSTR_LEN  = fetch_decode_unit_pkg::INSTR_LEN,
  parameter int IMEM_DEPTH = 64,
  // ROM image, word i at bits [i*INSTR_LEN +: INSTR_LEN]
  parameter logic [IMEM_DEPTH*INSTR_LEN-1:0] IMEM_INIT = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  input  logic [WORD-1:0]      write_data,
  output logic [WORD-1:0]      cur_pc,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 uncond_branch,
  output logic                 branch,
  output logic                 mem_read,
  output logic                 mem_to_reg,
  output logic                 mem_write,
  output logic                 ALU_src,
  output logic                 reg_write,
  output logic [1:0]           ALU_op,
  output logic [WORD-1:0]      read_data1,
  output logic [WORD-1:0]      read_data2,
  output logic [WORD-1:0]      sign_extended
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [WORD-1:0]  pc_r;
  logic [IDX_W-1:0] rom_idx_s;
  logic [10:0]      opcode_s;
  ctrl_t            ctrl_s;
  logic [WORD-1:0]  sext_s;
  logic [4:0]       raddr2_s;

  // PC register: redirect to the branch target or step one word
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= '0;
    end else if (pc_src) begin
      pc_r <= branch_target;
    end else begin
      pc_r <= pc_r + WORD'(3'd4);
    end
  end

  // Byte offset bits are dropped; higher PC bits fall off so the index wraps
  assign rom_idx_s   = pc_r[IDX_W+1:2];
  assign instruction = IMEM_INIT[rom_idx_s*INSTR_LEN +: INSTR_LEN];
  assign cur_pc      = pc_r;
  assign opcode_s    = instruction[31:21];

  // Control decode and immediate selection; unknown opcodes behave as a NOP
  always_comb begin
    ctrl_s = ctrl_t'('0);
    sext_s = '0;
    if (is_rtype(opcode_s)) begin
      ctrl_s.reg_write = 1'b1;
      ctrl_s.alu_op    = ALU_RTYPE;
    end else if (opcode_s == OP_LDUR) begin
      ctrl_s.alu_src    = 1'b1;
      ctrl_s.mem_to_reg = 1'b1;
      ctrl_s.reg_write  = 1'b1;
      ctrl_s.mem_read   = 1'b1;
      ctrl_s.alu_op     = ALU_ADD;
      sext_s = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (opcode_s == OP_STUR) begin
      ctrl_s.reg2_loc  = 1'b1;
      ctrl_s.alu_src   = 1'b1;
      ctrl_s.mem_write = 1'b1;
      ctrl_s.alu_op    = ALU_ADD;
      sext_s = {{(WORD-9){instruction[20]}}, instruction[20:12]};
    end else if (opcode_s[10:3] == OP_CBZ) begin
      ctrl_s.reg2_loc = 1'b1;
      ctrl_s.branch   = 1'b1;
      ctrl_s.alu_op   = ALU_BRANCH;
      sext_s = {{(WORD-19){instruction[23]}}, instruction[23:5]};
    end else if (opcode_s[10:5] == OP_B) begin
      ctrl_s.uncond_branch = 1'b1;
      ctrl_s.alu_op        = ALU_BRANCH;
      sext_s = {{(WORD-26){instruction[25]}}, instruction[25:0]};
    end else begin
      ctrl_s = ctrl_t'('0);
      sext_s = '0;
    end
  end

  assign uncond_branch = ctrl_s.uncond_branch;
  assign branch        = ctrl_s.branch;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign mem_write     = ctrl_s.mem_write;
  assign ALU_src       = ctrl_s.alu_src;
  assign reg_write     = ctrl_s.reg_write;
  assign ALU_op        = ctrl_s.alu_op;
  assign sign_extended = sext_s;

  // Stores and CBZ read Rt on the second port instead of Rm
  assign raddr2_s = ctrl_s.reg2_loc ? instruction[4:0] : instruction[20:16];

  reg_file_32x64 #(
    .WIDTH (WORD)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (ctrl_s.reg_write),
    .waddr  (instruction[4:0]),
    .wdata  (write_data),
    .raddr1 (instruction[9:5]),
    .raddr2 (raddr2_s),
    .rdata1 (read_data1),
    .rdata2 (read_data2)
  );

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed scoreboard bench for fetch_decode_unit: each step queues the expected
// front-end outputs for that cycle and a negedge monitor compares them.
module tb_fetch_decode_unit;

  localparam int DEPTH = 16;

  localparam logic [31:0] W_ADD9  = 32'h8B04_0069; // ADD X9,X3,X4
  localparam logic [31:0] W_LDUR  = 32'hF85F_8022; // LDUR X2,[X1,#-8]
  localparam logic [31:0] W_ADD3  = 32'h8B02_0023; // ADD X3,X1,X2
  localparam logic [31:0] W_ADD4  = 32'h8B03_0064; // ADD X4,X3,X3
  localparam logic [31:0] W_ADDZ  = 32'h8B02_003F; // ADD XZR,X1,X2
  localparam logic [31:0] W_ORR   = 32'hAA09_010A; // ORR X10,X8,X9
  localparam logic [31:0] W_ADD5  = 32'h8B1F_03E5; // ADD X5,XZR,XZR
  localparam logic [31:0] W_CBZ   = 32'hB400_0065; // CBZ X5,#3
  localparam logic [31:0] W_B     = 32'h17FF_FFFF; // B #-1
  localparam logic [31:0] W_NOP   = 32'h0000_0000;
  localparam logic [31:0] W_STUR  = 32'hF81F_8083; // STUR X3,[X4,#-8]
  localparam logic [31:0] W_ADD33 = 32'h8B03_0063; // ADD X3,X3,X3
  localparam logic [31:0] W_SUB   = 32'hCB04_0067; // SUB X7,X3,X4
  localparam logic [31:0] W_AND   = 32'h8A07_00E8; // AND X8,X7,X7

  localparam logic [DEPTH*32-1:0] PROG = {
    W_AND, W_SUB, W_ADD33, W_STUR, W_NOP, W_B, W_CBZ, W_ADD5,
    W_NOP, W_NOP, W_ORR, W_ADDZ, W_ADD4, W_ADD3, W_LDUR, W_ADD9
  };

  // {uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
  localparam logic [8:0] C_R    = 9'b0_0000_0110;
  localparam logic [8:0] C_LDUR = 9'b0_0110_1100;
  localparam logic [8:0] C_STUR = 9'b0_0001_1000;
  localparam logic [8:0] C_CBZ  = 9'b0_1000_0001;
  localparam logic [8:0] C_B    = 9'b1_0000_0001;
  localparam logic [8:0] C_NOP  = 9'b0_0000_0000;

  localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M4 = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] sx;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [63:0] branch_target;
  logic [63:0] write_data;
  logic [63:0] cur_pc;
  logic [31:0] instruction;
  logic        uncond_branch, branch, mem_read, mem_to_reg, mem_write, ALU_src, reg_write;
  logic [1:0]  ALU_op;
  logic [63:0] read_data1, read_data2, sign_extended;

  exp_t        exp_q[$];
  logic [31:0] rom_w [DEPTH];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc_cnt = 0;

  fetch_decode_unit #(
    .WORD       (64),
    .INSTR_LEN  (32),
    .IMEM_DEPTH (DEPTH),
    .IMEM_INIT  (PROG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .write_data    (write_data),
    .cur_pc        (cur_pc),
    .instruction   (instruction),
    .uncond_branch (uncond_branch),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .ALU_src       (ALU_src),
    .reg_write     (reg_write),
    .ALU_op        (ALU_op),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .sign_extended (sign_extended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle once stimulus starts queuing expectations
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("cur_pc", e.cyc, cur_pc, e.pc);
      check("instruction", e.cyc, {32'h0, instruction}, {32'h0, e.instr});
      check("controls", e.cyc,
            {55'h0, uncond_branch, branch, mem_read, mem_to_reg, mem_write, ALU_src, reg_write, ALU_op},
            {55'h0, e.ctrl});
      check("read_data1", e.cyc, read_data1, e.rd1);
      check("read_data2", e.cyc, read_data2, e.rd2);
      check("sign_extended", e.cyc, sign_extended, e.sx);
    end
  end

  task automatic step(input logic rst, input logic psrc, input logic [63:0] tgt, input logic [63:0] wd,
                      input logic [63:0] epc, input logic [8:0] ectrl,
                      input logic [63:0] erd1, input logic [63:0] erd2, input logic [63:0] esx);
    exp_t e;
    e.pc    = epc;
    e.instr = rom_w[epc[5:2]];
    e.ctrl  = ectrl;
    e.rd1   = erd1;
    e.rd2   = erd2;
    e.sx    = esx;
    e.cyc   = cyc_cnt;
    exp_q.push_back(e);
    reset         = rst;
    pc_src        = psrc;
    branch_target = tgt;
    write_data    = wd;
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom_w = '{W_ADD9, W_LDUR, W_ADD3, W_ADD4, W_ADDZ, W_ORR, W_NOP, W_NOP,
              W_ADD5, W_CBZ, W_B, W_NOP, W_STUR, W_ADD33, W_SUB, W_AND};
    reset         = 1'b1;
    pc_src        = 1'b0;
    branch_target = 64'h0;
    write_data    = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    //   rst   psrc  target        wdata         pc            ctrl    rd1           rd2           sext
    step(1'b0, 1'b0, 64'h0,        64'h9,        64'h0,        C_R,    64'h0,        64'h0,        64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h10,       64'h4,        C_LDUR, 64'h0,        64'h0,        M8);
    step(1'b0, 1'b0, 64'h0,        64'h1234,     64'h8,        C_R,    64'h0,        64'h10,       64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h55,       64'hC,        C_R,    64'h1234,     64'h1234,     64'h0);
    step(1'b0, 1'b1, 64'h20,       64'h55,       64'h10,       C_R,    64'h0,        64'h10,       64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h77,       64'h20,       C_R,    64'h0,        64'h0,        64'h0);
    step(1'b0, 1'b0, 64'h0,        64'hDEAD,     64'h24,       C_CBZ,  64'h1234,     64'h77,       64'h3);
    step(1'b0, 1'b0, 64'h0,        64'hBEEF,     64'h28,       C_B,    64'h0,        64'h0,        M1);
    step(1'b0, 1'b0, 64'h0,        64'hF00D,     64'h2C,       C_NOP,  64'h0,        64'h0,        64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h99,       64'h30,       C_STUR, 64'h55,       64'h1234,     M8);
    step(1'b0, 1'b0, 64'h0,        64'h4321,     64'h34,       C_R,    64'h1234,     64'h1234,     64'h0);
    step(1'b0, 1'b0, 64'h0,        64'hAA,       64'h38,       C_R,    64'h4321,     64'h55,       64'h0);
    step(1'b0, 1'b1, 64'h14,       64'hBB,       64'h3C,       C_R,    64'hAA,       64'hAA,       64'h0);
    step(1'b0, 1'b1, M4,           64'hCC,       64'h14,       C_R,    64'hBB,       64'h9,        64'h0);
    step(1'b0, 1'b0, 64'h0,        64'hBC,       M4,           C_R,    64'hAA,       64'hAA,       64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h1,        64'h0,        C_R,    64'h4321,     64'h55,       64'h0);
    step(1'b1, 1'b0, 64'h0,        64'h5,        64'h4,        C_LDUR, 64'h0,        64'h0,        M8);
    step(1'b0, 1'b0, 64'h0,        64'h0,        64'h0,        C_R,    64'h0,        64'h0,        64'h0);
    step(1'b0, 1'b0, 64'h0,        64'h0,        64'h4,        C_LDUR, 64'h0,        64'h0,        M8);
    @(negedge clk);
    #1;
    check("queue_drained", cyc_cnt, 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
